// File: rtl/stack_controller.sv
// stack_controller: LIFO stack built from a register file, with push, pop,
// replace-top (push+pop), synchronous clear, a one-cycle Ack pulse and sticky
// overflow/underflow flags. Count is the only pointer; Top is decoded from it.
module stack_controller #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                     Clk,
  input  logic                     Rstn,
  input  logic                     Push,
  input  logic                     Pop,
  input  logic                     Clr,
  input  logic [WIDTH-1:0]         D,
  output logic [WIDTH-1:0]         Top,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Empty,
  output logic                     Full,
  output logic                     Ack,
  output logic                     Overflow,
  output logic                     Underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]    count_q, count_d;
  logic             ack_q, ack_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             empty_w, full_w;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);
  // Index of the current top entry; only meaningful while the stack is non-empty.
  assign top_idx = AW'(count_q - CW'(1));

  // Next-state decode: Clr beats everything, then push+pop, then push, then pop.
  always_comb begin
    count_d = count_q;
    ack_d   = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_idx  = count_q[AW-1:0];
    if (Clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (Push && Pop) begin
      wr_en = 1'b1;
      ack_d = 1'b1;
      if (empty_w) begin
        // Nothing to replace: behaves as a plain push into entry 0.
        wr_idx  = '0;
        count_d = CW'(1);
      end else begin
        // Replace the top entry in place; depth is unchanged, even when full.
        wr_idx = top_idx;
      end
    end else if (Push) begin
      if (full_w) begin
        ovf_d = 1'b1;
      end else begin
        wr_en   = 1'b1;
        count_d = count_q + CW'(1);
        ack_d   = 1'b1;
      end
    end else if (Pop) begin
      if (empty_w) begin
        unf_d = 1'b1;
      end else begin
        count_d = count_q - CW'(1);
        ack_d   = 1'b1;
      end
    end
  end

  // Control state: asynchronously cleared; storage is deliberately not reset.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      count_q <= '0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // One register per stack entry, loaded only when the decode selects it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Entry write: contents survive pop, clear and reset.
    always_ff @(posedge Clk) begin
      if (wr_en && (wr_idx == AW'(gi))) begin
        mem_q[gi] <= D;
      end
    end
  end

  assign Top       = empty_w ? '0 : mem_q[top_idx];
  assign Count     = count_q;
  assign Empty     = empty_w;
  assign Full      = full_w;
  assign Ack       = ack_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller (WIDTH=4, DEPTH=8). Each step drives one
// request, waits for the edge, and checks outputs 1 ns later against
// hand-computed values.
module tb_stack_controller;

  logic       Clk = 1'b0;
  logic       Rstn = 1'b0;
  logic       Push = 1'b0;
  logic       Pop = 1'b0;
  logic       Clr = 1'b0;
  logic [3:0] D = 4'h0;
  logic [3:0] Top;
  logic [3:0] Count;
  logic       Empty, Full, Ack, Overflow, Underflow;

  int n_vec = 0;
  int n_err = 0;

  stack_controller #(.WIDTH(4), .DEPTH(8)) dut (
    .Clk(Clk), .Rstn(Rstn), .Push(Push), .Pop(Pop), .Clr(Clr), .D(D),
    .Top(Top), .Count(Count), .Empty(Empty), .Full(Full), .Ack(Ack),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one request across one rising edge, then return to idle 1 ns later.
  task automatic op(input logic pu, input logic po, input logic cl, input logic [3:0] dv);
    Push = pu; Pop = po; Clr = cl; D = dv;
    @(posedge Clk);
    #1;
    Push = 1'b0; Pop = 1'b0; Clr = 1'b0; D = 4'h0;
    $display("op push=%0b pop=%0b clr=%0b d=%0h -> count=%0d top=%0h ack=%0b ovf=%0b unf=%0b",
             pu, po, cl, dv, Count, Top, Ack, Overflow, Underflow);
  endtask

  task automatic st(input string tag, input int c, input int t, input int a,
                    input int o, input int u);
    chk({tag, ".count"}, 32'(Count), 32'(c));
    chk({tag, ".top"},   32'(Top),   32'(t));
    chk({tag, ".ack"},   32'(Ack),   32'(a));
    chk({tag, ".ovf"},   32'(Overflow),  32'(o));
    chk({tag, ".unf"},   32'(Underflow), 32'(u));
    chk({tag, ".empty"}, 32'(Empty), (c == 0) ? 32'd1 : 32'd0);
    chk({tag, ".full"},  32'(Full),  (c == 8) ? 32'd1 : 32'd0);
  endtask

  initial begin
    // Reset state, observed before any clock edge.
    #2;
    st("reset", 0, 0, 0, 0, 0);
    #10 Rstn = 1'b1;   // released between edges (t=12)
    @(posedge Clk); #1;

    // Pop from empty sets Underflow, no Ack.
    op(0, 1, 0, 4'h0); st("pop_empty", 0, 0, 0, 0, 1);
    // Push+Pop on empty acts as push.
    op(1, 1, 0, 4'h5); st("pushpop_empty", 1, 5, 1, 0, 1);
    op(0, 0, 0, 4'h0); st("idle1", 1, 5, 0, 0, 1);
    op(0, 1, 0, 4'h0); st("pop_to0", 0, 0, 1, 0, 1);

    // Clear flags to start the basic push/pop sequence cleanly.
    op(0, 0, 1, 4'h0); st("clr0", 0, 0, 0, 0, 0);
    op(1, 0, 0, 4'h1); st("push1", 1, 1, 1, 0, 0);
    op(1, 0, 0, 4'h2); st("push2", 2, 2, 1, 0, 0);
    op(1, 0, 0, 4'h3); st("push3", 3, 3, 1, 0, 0);
    op(0, 0, 0, 4'h0); st("idle2", 3, 3, 0, 0, 0);
    op(0, 1, 0, 4'h0); st("pop3", 2, 2, 1, 0, 0);
    op(1, 0, 0, 4'h3); st("repush3", 3, 3, 1, 0, 0);
    // Replace top with 9.
    op(1, 1, 0, 4'h9); st("replace9", 3, 9, 1, 0, 0);

    // Fill to full: stack becomes 1,2,9,4,5,6,7,8.
    op(1, 0, 0, 4'h4); st("push4", 4, 4, 1, 0, 0);
    op(1, 0, 0, 4'h5); st("push5", 5, 5, 1, 0, 0);
    op(1, 0, 0, 4'h6); st("push6", 6, 6, 1, 0, 0);
    op(1, 0, 0, 4'h7); st("push7", 7, 7, 1, 0, 0);
    op(1, 0, 0, 4'h8); st("push8", 8, 8, 1, 0, 0);
    // Replace at full: no overflow.
    op(1, 1, 0, 4'hA); st("replace_full", 8, 10, 1, 0, 0);
    // Push at full: overflow, Top unchanged.
    op(1, 0, 0, 4'hF); st("push_full", 8, 10, 0, 1, 0);
    op(0, 1, 0, 4'h0); st("pop_after_ovf", 7, 7, 1, 1, 0);
    op(0, 1, 0, 4'h0); st("pop6", 6, 6, 1, 1, 0);
    op(0, 1, 0, 4'h0); st("pop5", 5, 5, 1, 1, 0);

    // Clear with Push asserted: clear wins, storage of entry 0 not written.
    op(1, 0, 1, 4'hE); st("clr_push", 0, 0, 0, 0, 0);
    op(0, 0, 0, 4'h0); st("idle3", 0, 0, 0, 0, 0);

    // Build depth 4 then reset asynchronously between edges.
    op(1, 0, 0, 4'h1); st("r_push1", 1, 1, 1, 0, 0);
    op(1, 0, 0, 4'h2); st("r_push2", 2, 2, 1, 0, 0);
    op(0, 1, 0, 4'h0); st("r_pop", 1, 1, 1, 0, 0);
    op(0, 1, 0, 4'h0); st("r_pop2", 0, 0, 1, 0, 0);
    op(0, 1, 0, 4'h0); st("r_unf", 0, 0, 0, 0, 1);
    op(1, 0, 0, 4'h2); st("r_pushA", 1, 2, 1, 0, 1);
    op(1, 0, 0, 4'h3); st("r_pushB", 2, 3, 1, 0, 1);
    op(1, 0, 0, 4'h4); st("r_pushC", 3, 4, 1, 0, 1);
    op(1, 0, 0, 4'h5); st("r_pushD", 4, 5, 1, 0, 1);
    #1 Rstn = 1'b0;    // mid-cycle, Ack currently high
    #1;
    st("async_rst", 0, 0, 0, 0, 0);
    #1 Rstn = 1'b1;
    op(1, 0, 0, 4'h7); st("post_rst_push7", 1, 7, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stack_controller.md
STACK_CONTROLLER -- requirements
Module: stack_controller

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of stack entries (power of two, minimum 2).
REQ-003 The block SHALL have port Clk  input  1  rising-edge clock for all state.
REQ-004 The block SHALL have port Rstn  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port Push  input  1  push request, sampled on the Clk rising edge.
REQ-006 The block SHALL have port Pop  input  1  pop request, sampled on the Clk rising edge.
REQ-007 The block SHALL have port Clr  input  1  synchronous clear of stack and flags.
REQ-008 The block SHALL have port D  input  WIDTH  data word to push.
REQ-009 The block SHALL have port Top  output  WIDTH  current top-of-stack word.
REQ-010 The block SHALL have port Count  output  log2(DEPTH)+1  number of valid entries.
REQ-011 The block SHALL have ports Empty and Full  output  1 each  Count==0 and Count==DEPTH respectively.
REQ-012 The block SHALL have port Ack  output  1  registered pulse: the previous edge accepted an operation.
REQ-013 The block SHALL have ports Overflow and Underflow  output  1 each  sticky error flags.

Function
REQ-014 Storage SHALL be DEPTH x WIDTH internal registers; entry i is written only by the controller.
REQ-015 Priority SHALL be Clr > (Push and Pop) > Push > Pop, evaluated on each rising Clk edge.
REQ-016 With Clr=1: Count->0, Overflow->0, Underflow->0, Ack->0; storage unchanged; Push and Pop ignored.
REQ-017 Push only, not Full: entry[Count]<=D, Count<=Count+1, Ack<=1 on that edge.
REQ-018 Push only, Full: no write, Count unchanged, Overflow<=1, Ack<=0.
REQ-019 Pop only, not Empty: Count<=Count-1, Ack<=1; popped entry is not cleared.
REQ-020 Pop only, Empty: Count stays 0, Underflow<=1, Ack<=0.
REQ-021 Push and Pop together, not Empty: entry[Count-1]<=D (replace top), Count unchanged, Ack<=1, no flag change (also when Full).
REQ-022 Push and Pop together, Empty: treated as push only (Count->1, entry[0]<=D, Ack<=1), Underflow unchanged.
REQ-023 Neither request and no Clr: all state held, Ack<=0.
REQ-024 Top SHALL be combinational: entry[Count-1] when Count>0, else all zeros.
REQ-025 Empty, Full SHALL be combinational decodes of Count; Count never exceeds DEPTH and never wraps.
REQ-026 Overflow and Underflow SHALL remain 1 once set until Clr or reset.
REQ-027 Ack SHALL be high for exactly one cycle per accepted operation, low otherwise.

Reset
REQ-028 Rstn=0 SHALL immediately (without Clk) force Count=0, Ack=0, Overflow=0, Underflow=0, hence Empty=1, Full=0, Top=0.
REQ-029 Storage contents SHALL NOT be reset; they are unobservable while Count=0.
REQ-030 Reset asserted mid-operation SHALL abort it; the first edge after Rstn deasserts SHALL be processed normally.

Verification (WIDTH=4, DEPTH=8)
REQ-031 Reset, push 1,2,3 -> Count=3, Top=3, Ack high one cycle after each push; pop -> Top=2, Count=2.
REQ-032 Push 8 words then push 4'hF -> Full=1, Count=8, Top unchanged, Overflow=1, Ack=0; then pop -> Count=7, Overflow stays 1.
REQ-033 From Empty, Pop -> Underflow=1, Count=0, Top=0; then Push+Pop with D=5 -> Count=1, Top=5, Ack=1.
REQ-034 Count=3, Top=3, Push+Pop with D=9 -> Count=3, Top=9; repeat at Full -> Count=8, Overflow=0.
REQ-035 Flags set, Count=5, Clr with Push=1 -> Count=0, Empty=1, both flags 0, Ack=0.
REQ-036 Count=4, drop Rstn between edges -> Count=0, Empty=1 immediately; release, push 7 -> Count=1, Top=7.
